calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter MUL_STEPS, default 8, meaning the number of shift-add iterations used for multiply.
REQ-002 SHALL have port clock, input, 1 bit: single system clock; all flops use its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Switches, input, 8 bits: two's-complement operand entry.
REQ-005 SHALL have port Op, input, 2 bits: 00 add, 01 subtract, 10 multiply, 11 negate A.
REQ-006 SHALL have port Enter, input, 1 bit: asynchronous push-button, active-high.
REQ-007 SHALL have port EightBitNumber, output, 8 bits: registered two's-complement value sent to the display stage.
REQ-008 SHALL have port Overflow, output, 1 bit: the result is out of the range -128..127.
REQ-009 SHALL have port Busy, output, 1 bit: high while in COMPUTE.
REQ-010 SHALL have port State, output, 2 bits: current FSM state encoding.

Function
REQ-011 SHALL pass Enter through a 2-flop synchronizer and generate a 1-cycle press pulse on a synchronized 0->1 transition.
REQ-012 SHALL implement a 4-state FSM with encodings LOAD_A=00, LOAD_B=01, COMPUTE=10, SHOW=11.
REQ-013 SHALL behave as follows in LOAD_A: EightBitNumber follows Switches with 1-cycle latency; a press captures A=Switches; then Op=11 goes to COMPUTE and any other Op goes to LOAD_B.
REQ-014 SHALL behave as follows in LOAD_B: EightBitNumber follows Switches with 1-cycle latency; a press captures B=Switches and Op, then goes to COMPUTE.
REQ-015 SHALL latch Op at the press that enters COMPUTE; changes to Op during COMPUTE SHALL be ignored.
REQ-016 SHALL complete add, subtract and negate in exactly 1 COMPUTE cycle, then go to SHOW.
REQ-017 SHALL compute multiply as follows:
- unsigned shift-add on |A| and |B| using a 16-bit accumulator, taking exactly MUL_STEPS COMPUTE cycles;
- then apply the sign (A[7] XOR B[7]);
- then go to SHOW.
REQ-018 SHALL compute arithmetic at 9-bit sign-extended width, or 16-bit width for multiply.
REQ-019 SHALL set Overflow when the true result is not representable in 8 bits, including -(-128) and (-128)*(-1).
REQ-020 SHALL update EightBitNumber and Overflow in the cycle COMPUTE exits and hold them throughout SHOW.
REQ-021 SHALL, in SHOW, on a press: clear Overflow, load A with the displayed result for chaining, and go to LOAD_B.
REQ-022 SHALL ignore presses during COMPUTE; they SHALL NOT be queued.
REQ-023 SHALL hold EightBitNumber at its pre-COMPUTE value while Busy is high.
REQ-024 SHALL treat |-128| as 128 in the multiply magnitude path, using 8-bit unsigned magnitudes.

Reset
REQ-025 SHALL, while Reset is high at a clock edge, force: State=LOAD_A, A=0, B=0, latched Op=00, accumulator=0, EightBitNumber=0, Overflow=0, Busy=0, and synchronizer and edge flops=0.
REQ-026 SHALL, on Reset asserted mid-COMPUTE, abort the operation with no result written, and SHALL recover in the next cycle.
REQ-027 SHALL give Reset priority over a simultaneous press.

Configuration
REQ-028 SHALL, with CALC_SATURATE_EN defined, clamp overflowing results to +127 (0x7F) or -128 (0x80) according to the true sign, with Overflow still asserted.
REQ-029 SHALL, without CALC_SATURATE_EN, output the low 8 bits of the result (wrap-around), with Overflow asserted.

Verification
REQ-030 SHALL verify add: A=0x05, B=0xFD (-3), Op=00 -> EightBitNumber=0x02, Overflow=0, State=11 one cycle after the press pulse.
REQ-031 SHALL verify add overflow: A=0x64 (100), B=0x32 (50), Op=00 -> Overflow=1; EightBitNumber=0x96 without the macro, 0x7F with CALC_SATURATE_EN.
REQ-032 SHALL verify multiply: A=0xFA (-6), B=0x07, Op=10 -> Busy high for exactly 8 cycles, then EightBitNumber=0xD6 (-42), Overflow=0.
REQ-033 SHALL verify negate: A=0x80, Op=11 -> Overflow=1; EightBitNumber=0x80 with or without the macro.
REQ-034 SHALL verify ignored press and reset abort: a press mid-multiply has no effect; Reset asserted at COMPUTE cycle 4 -> next cycle State=00, EightBitNumber=0x00, Busy=0.
REQ-035 SHALL verify chaining: from SHOW with 0x02, a press, then B=0x03, Op=01 -> EightBitNumber=0xFF (-1).

Source files
------------

// File: rtl/calc_sequencer.sv
// Two-operand calculator sequencer: synchronized Enter, LOAD_A/LOAD_B/COMPUTE/SHOW FSM, shift-add multiply.
// Define CALC_SATURATE_EN to clamp overflowing results instead of wrapping them.
module calc_sequencer #(
  parameter int MUL_STEPS = 8
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] Switches,
  input  logic [1:0] Op,
  input  logic       Enter,
  output logic [7:0] EightBitNumber,
  output logic       Overflow,
  output logic       Busy,
  output logic [1:0] State
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    COMPUTE = 2'b10,
    SHOW    = 2'b11
  } state_t;

  state_t           state_reg;
  logic [7:0]       a_reg, b_reg, num_reg;
  logic [1:0]       op_reg;
  logic             ovf_reg, busy_reg;
  logic [15:0]      acc_reg, mcand_reg;
  logic [7:0]       mplier_reg;
  logic [CNT_W-1:0] step_reg;
  logic             enter_meta_reg, enter_sync_reg, enter_prev_reg;

  logic       press;
  logic [7:0] abs_a, abs_sw;
  logic [8:0] a9, b9, sum9, diff9, neg9;
  logic [15:0] acc_next;
  logic       mul_neg, mul_ovf, mul_last, compute_done;
  logic [7:0] mul_lo, res_lo, res8;
  logic       res_ovf;

  assign press = enter_sync_reg & ~enter_prev_reg;

  // |-128| comes out as 8'h80, i.e. 128 unsigned, which is what the multiplier wants.
  assign abs_a  = a_reg[7]    ? (8'd0 - a_reg)    : a_reg;
  assign abs_sw = Switches[7] ? (8'd0 - Switches) : Switches;

  assign a9    = {a_reg[7], a_reg};
  assign b9    = {b_reg[7], b_reg};
  assign sum9  = a9 + b9;
  assign diff9 = a9 - b9;
  assign neg9  = 9'd0 - a9;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 16'd0);
  assign mul_neg  = a_reg[7] ^ b_reg[7];
  assign mul_lo   = mul_neg ? (8'd0 - acc_next[7:0]) : acc_next[7:0];
  assign mul_ovf  = mul_neg ? (acc_next > 16'd128) : (acc_next > 16'd127);
  assign mul_last = (step_reg == CNT_W'(MUL_STEPS - 1));
  assign compute_done = (op_reg != 2'b10) || mul_last;

  always_comb begin
    res_lo  = sum9[7:0];
    res_ovf = sum9[8] ^ sum9[7];
    case (op_reg)
      2'b01: begin
        res_lo  = diff9[7:0];
        res_ovf = diff9[8] ^ diff9[7];
      end
      2'b10: begin
        res_lo  = mul_lo;
        res_ovf = mul_ovf;
      end
      2'b11: begin
        res_lo  = neg9[7:0];
        res_ovf = (a_reg == 8'h80);
      end
      default: ;
    endcase
  end

`ifdef CALC_SATURATE_EN
  logic res_neg;

  always_comb begin
    res_neg = sum9[8];
    case (op_reg)
      2'b01:   res_neg = diff9[8];
      2'b10:   res_neg = mul_neg;
      2'b11:   res_neg = neg9[8];
      default: ;
    endcase
    // Negating -128 keeps 0x80 on the display in both builds; only Overflow flags it.
    if (res_ovf && (op_reg != 2'b11))
      res8 = res_neg ? 8'h80 : 8'h7F;
    else
      res8 = res_lo;
  end
`else
  assign res8 = res_lo;
`endif

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_reg      <= LOAD_A;
      a_reg          <= 8'd0;
      b_reg          <= 8'd0;
      op_reg         <= 2'b00;
      num_reg        <= 8'd0;
      ovf_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      acc_reg        <= 16'd0;
      mcand_reg      <= 16'd0;
      mplier_reg     <= 8'd0;
      step_reg       <= '0;
      enter_meta_reg <= 1'b0;
      enter_sync_reg <= 1'b0;
      enter_prev_reg <= 1'b0;
    end else begin
      enter_meta_reg <= Enter;
      enter_sync_reg <= enter_meta_reg;
      enter_prev_reg <= enter_sync_reg;
      case (state_reg)
        LOAD_A: begin
          num_reg <= Switches;
          if (press) begin
            a_reg <= Switches;
            if (Op == 2'b11) begin
              op_reg    <= Op;
              busy_reg  <= 1'b1;
              state_reg <= COMPUTE;
            end else begin
              state_reg <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          num_reg <= Switches;
          if (press) begin
            b_reg      <= Switches;
            op_reg     <= Op;
            acc_reg    <= 16'd0;
            mcand_reg  <= {8'd0, abs_a};
            mplier_reg <= abs_sw;
            step_reg   <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Presses land here and are simply dropped; num_reg holds the pre-compute value.
          if (compute_done) begin
            num_reg   <= res8;
            ovf_reg   <= res_ovf;
            busy_reg  <= 1'b0;
            state_reg <= SHOW;
          end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= {mcand_reg[14:0], 1'b0};
            mplier_reg <= {1'b0, mplier_reg[7:1]};
            step_reg   <= step_reg + CNT_W'(1);
          end
        end
        SHOW: begin
          if (press) begin
            ovf_reg   <= 1'b0;
            a_reg     <= num_reg;
            state_reg <= LOAD_B;
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

  assign EightBitNumber = num_reg;
  assign Overflow       = ovf_reg;
  assign Busy           = busy_reg;
  assign State          = state_reg;

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus pushes expected results, a negedge monitor
// checks each entry into SHOW (value, overflow flag and number of Busy cycles).
module tb_calc_sequencer;

  logic       clock = 1'b0;
  logic       Reset;
  logic [7:0] Switches;
  logic [1:0] Op;
  logic       Enter;
  logic [7:0] EightBitNumber;
  logic       Overflow;
  logic       Busy;
  logic [1:0] State;

  calc_sequencer #(.MUL_STEPS(8)) dut (
    .clock(clock),
    .Reset(Reset),
    .Switches(Switches),
    .Op(Op),
    .Enter(Enter),
    .EightBitNumber(EightBitNumber),
    .Overflow(Overflow),
    .Busy(Busy),
    .State(State)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] num;
    logic       ovf;
    int         busy;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  logic [1:0] prev_state = 2'b00;
  int busy_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: counts Busy cycles and checks the result each time SHOW is entered.
  always @(negedge clock) begin
    if (Busy === 1'b1)
      busy_run = (prev_state == 2'b10) ? busy_run + 1 : 1;
    if (State === 2'b11 && prev_state !== 2'b11) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_num"}, {24'd0, EightBitNumber}, {24'd0, e.num});
        check({e.name, "_ovf"}, {31'd0, Overflow}, {31'd0, e.ovf});
        check({e.name, "_busy_cycles"}, busy_run, e.busy);
      end
    end
    prev_state = State;
  end

  task automatic push(input string name, input logic [7:0] num, input logic ovf, input int busy);
    exp_t x;
    x.name = name;
    x.num  = num;
    x.ovf  = ovf;
    x.busy = busy;
    sb.push_back(x);
  endtask

  task automatic do_reset;
    @(negedge clock);
    Reset = 1'b1;
    Enter = 1'b0;
    repeat (2) @(negedge clock);
    Reset = 1'b0;
  endtask

  // Held long enough for the synchronizer plus one FSM edge.
  task automatic press;
    Enter = 1'b1;
    repeat (3) @(negedge clock);
    Enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_show(input string name);
    int n = 0;
    while (State !== 2'b11 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, "_reach_show"}, {30'd0, State}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; Enter = 1'b0; Switches = 8'h00; Op = 2'b00;
    repeat (3) @(negedge clock);
    check("reset_state", {30'd0, State}, 32'd0);
    check("reset_num", {24'd0, EightBitNumber}, 32'd0);
    check("reset_ovf", {31'd0, Overflow}, 32'd0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;

    Switches = 8'h5A;
    repeat (2) @(negedge clock);
    check("load_a_follow", {24'd0, EightBitNumber}, 32'h5A);

    // 5 + (-3) = 2, then chain 2 - 3 = -1
    Switches = 8'h05; Op = 2'b00;
    press();
    check("after_a_press_state", {30'd0, State}, 32'd1);
    Switches = 8'hFD;
    push("add", 8'h02, 1'b0, 1);
    press();
    wait_show("add");
    Switches = 8'h03; Op = 2'b01;
    press();
    check("chain_state", {30'd0, State}, 32'd1);
    check("chain_ovf_clear", {31'd0, Overflow}, 32'd0);
    push("chain_sub", 8'hFF, 1'b0, 1);
    press();
    wait_show("chain_sub");

    // 100 + 50 overflows
    do_reset();
    Switches = 8'h64; Op = 2'b00;
    press();
    Switches = 8'h32;
`ifdef CALC_SATURATE_EN
    push("add_ovf", 8'h7F, 1'b1, 1);
`else
    push("add_ovf", 8'h96, 1'b1, 1);
`endif
    press();
    wait_show("add_ovf");

    // -(-128)
    do_reset();
    Switches = 8'h80; Op = 2'b11;
    push("neg_min", 8'h80, 1'b1, 1);
    press();
    wait_show("neg_min");

    // -128 - 1 overflows negative
    do_reset();
    Switches = 8'h80; Op = 2'b01;
    press();
    Switches = 8'h01;
`ifdef CALC_SATURATE_EN
    push("sub_ovf", 8'h80, 1'b1, 1);
`else
    push("sub_ovf", 8'h7F, 1'b1, 1);
`endif
    press();
    wait_show("sub_ovf");

    // -6 * 7 = -42, with an ignored press and Op change mid-multiply
    do_reset();
    Switches = 8'hFA; Op = 2'b10;
    press();
    Switches = 8'h07;
    push("mul", 8'hD6, 1'b0, 8);
    press();
    Switches = 8'h00; Op = 2'b00;
    @(negedge clock);
    check("hold_during_busy", {24'd0, EightBitNumber}, 32'h07);
    check("busy_mid_mul", {31'd0, Busy}, 32'd1);
    press();
    wait_show("mul");
    repeat (4) @(negedge clock);
    check("press_not_queued", {30'd0, State}, 32'd3);
    check("show_hold", {24'd0, EightBitNumber}, 32'hD6);

    // (-128) * (-1) = +128 overflows
    do_reset();
    Switches = 8'h80; Op = 2'b10;
    press();
    Switches = 8'hFF;
`ifdef CALC_SATURATE_EN
    push("mul_ovf", 8'h7F, 1'b1, 8);
`else
    push("mul_ovf", 8'h80, 1'b1, 8);
`endif
    press();
    wait_show("mul_ovf");

    // Reset during COMPUTE cycle 4 aborts the multiply
    do_reset();
    Switches = 8'h03; Op = 2'b10;
    press();
    Switches = 8'h04;
    Enter = 1'b1;
    begin
      int n = 0;
      while (Busy !== 1'b1 && n < 20) begin
        @(negedge clock);
        n++;
      end
    end
    check("abort_busy_seen", {31'd0, Busy}, 32'd1);
    repeat (3) @(negedge clock);
    Reset = 1'b1; Enter = 1'b0;
    @(negedge clock);
    check("abort_state", {30'd0, State}, 32'd0);
    check("abort_num", {24'd0, EightBitNumber}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_ovf", {31'd0, Overflow}, 32'd0);
    Reset = 1'b0;
    repeat (12) @(negedge clock);
    check("abort_no_result", {30'd0, State}, 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
